// File: rtl/iiitb_fifo_pkg.sv
// Shared constants and elaboration helpers for the iiitb parametrised FIFO.
// Build option: IIITB_PFIFO_FWFT_EN selects first-word-fall-through output.
package iiitb_fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_MARGIN = 2;

  // Ceiling log2, evaluated at elaboration time for address widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit margin_ok(input int margin, input int depth);
    return (margin >= 0) && (margin < depth);
  endfunction

  function automatic bit width_ok(input int width);
    return width >= 1;
  endfunction

endpackage

// File: rtl/iiitb_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read.
// Contents carry no reset so a flush or reset leaves the stored words in place.
module iiitb_fifo_mem
  import iiitb_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = clog2(DEF_DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/iiitb_pfifo.sv
// Parametrised single-clock FIFO with guarded push/pop, thresholds and sticky errors.
// Build option: IIITB_PFIFO_FWFT_EN gives a combinational head-of-queue output.
module iiitb_pfifo
  import iiitb_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_MARGIN,
  parameter int AE_MARGIN = DEF_MARGIN,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             clear,
  input  logic             write,
  input  logic [WIDTH-1:0] iData,
  input  logic             read,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("iiitb_pfifo: WIDTH must be at least 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("iiitb_pfifo: DEPTH must be a power of two, at least 2");
  end
  if (!margin_ok(AF_MARGIN, DEPTH)) begin : g_bad_af
    $error("iiitb_pfifo: AF_MARGIN must lie in 0..DEPTH-1");
  end
  if (!margin_ok(AE_MARGIN, DEPTH)) begin : g_bad_ae
    $error("iiitb_pfifo: AE_MARGIN must lie in 0..DEPTH-1");
  end

  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
  localparam logic [AW:0] AF_LEVEL = (AW + 1)'(DEPTH - AF_MARGIN);
  localparam logic [AW:0] AE_LEVEL = (AW + 1)'(AE_MARGIN);

  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic [WIDTH-1:0] rdata;
  logic             push_ok;
  logic             pop_ok;

  // Handshake: write/read are requests sampled on the rising edge. A push is
  // accepted only while !full, a pop only while !empty; there is no stall, a
  // rejected request is dropped and recorded in overflow/underflow. clear wins
  // over both requests in the same cycle.
  assign push_ok = write && !full && !clear;
  assign pop_ok  = read && !empty && !clear;

  // Pointers carry a wrap bit, so wp - rp is the true occupancy 0..DEPTH.
  assign count        = wp - rp;
  assign empty        = (wp == rp);
  assign full         = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  iiitb_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (push_ok),
    .waddr (wp[AW-1:0]),
    .wdata (iData),
    .raddr (rp[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wp        <= '0;
      rp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wp        <= '0;
      rp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wp <= wp + PTR_ONE;
      if (pop_ok)  rp <= rp + PTR_ONE;
      // full is judged before this edge's pop, so a concurrent read never frees a slot.
      if (write && full)  overflow  <= 1'b1;
      if (read  && empty) underflow <= 1'b1;
    end
  end

`ifdef IIITB_PFIFO_FWFT_EN
  assign oData  = rdata;
  assign oValid = !empty;
`else
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      oData  <= '0;
      oValid <= 1'b0;
    end else begin
      oValid <= pop_ok;
      if (pop_ok) oData <= rdata;
    end
  end
`endif

endmodule

// File: tb/tb_iiitb_pfifo.sv
// Directed self-checking bench for iiitb_pfifo (DEPTH=16, WIDTH=8, margins 2).
// Honours IIITB_PFIFO_FWFT_EN to check the matching oData timing.
module tb_iiitb_pfifo;
  import iiitb_fifo_pkg::*;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 2;
  localparam int AE = 2;
  localparam int AW = 4;

  logic          CLK;
  logic          RSTn;
  logic          clear;
  logic          write;
  logic          read;
  logic [W-1:0]  iData;
  logic [W-1:0]  oData;
  logic          oValid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  logic [W-1:0]  exp_q[$];
  logic          exp_ovf;
  logic          exp_unf;
  logic [W-1:0]  last_pop;
  int            n_tests;
  int            n_fail;

  iiitb_pfifo #(
    .WIDTH     (W),
    .DEPTH     (D),
    .AF_MARGIN (AF),
    .AE_MARGIN (AE)
  ) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .clear        (clear),
    .write        (write),
    .iData        (iData),
    .read         (read),
    .oData        (oData),
    .oValid       (oValid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    int n;
    n = exp_q.size();
    check({tag, "_count"}, 32'(count), 32'(n));
    check({tag, "_empty"}, 32'(empty), 32'(n == 0));
    check({tag, "_full"}, 32'(full), 32'(n == D));
    check({tag, "_afull"}, 32'(almost_full), 32'(n >= D - AF));
    check({tag, "_aempty"}, 32'(almost_empty), 32'(n <= AE));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Driver tasks; each keeps the scoreboard in step with what the FIFO should hold.
  task automatic push(input logic [W-1:0] d);
    write = 1'b1;
    iData = d;
    tick();
    write = 1'b0;
    if (exp_q.size() < D) exp_q.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      read = 1'b1;
      tick();
      read = 1'b0;
      exp_unf = 1'b1;
      check({tag, "_unf_valid"}, 32'(oValid), 32'(0));
      return;
    end
    e = exp_q.pop_front();
`ifdef IIITB_PFIFO_FWFT_EN
    check({tag, "_head"}, 32'(oData), 32'(e));
    check({tag, "_valid"}, 32'(oValid), 32'(1));
    read = 1'b1;
    tick();
    read = 1'b0;
`else
    read = 1'b1;
    tick();
    read = 1'b0;
    check({tag, "_data"}, 32'(oData), 32'(e));
    check({tag, "_valid"}, 32'(oValid), 32'(1));
`endif
    last_pop = e;
  endtask

  task automatic push_pop(input logic [W-1:0] d, input string tag);
    logic [W-1:0] e;
    logic         was_full;
    e = exp_q[0];
    was_full = (exp_q.size() == D);
`ifdef IIITB_PFIFO_FWFT_EN
    check({tag, "_head"}, 32'(oData), 32'(e));
`endif
    write = 1'b1;
    read  = 1'b1;
    iData = d;
    tick();
    write = 1'b0;
    read  = 1'b0;
    void'(exp_q.pop_front());
    if (was_full) exp_ovf = 1'b1;
    else exp_q.push_back(d);
`ifndef IIITB_PFIFO_FWFT_EN
    check({tag, "_data"}, 32'(oData), 32'(e));
`endif
    last_pop = e;
  endtask

  task automatic flush();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    last_pop = '0;
    RSTn  = 1'b0;
    clear = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    iData = '0;

    // Reset state
    #12;
    check_status("rst");
    check("rst_ovalid", 32'(oValid), 32'(0));
`ifndef IIITB_PFIFO_FWFT_EN
    check("rst_odata", 32'(oData), 32'(0));
`endif
    RSTn = 1'b1;
    tick();

    // Fill 0x01..0x10; almost_full first appears at count 14
    for (int i = 1; i <= D; i++) begin
      push(W'(i));
      check_status("fill");
      if (i == 13) check("af_at13", 32'(almost_full), 32'(0));
      if (i == 14) check("af_at14", 32'(almost_full), 32'(1));
    end
    check("fill_count16", 32'(count), 32'(16));
    check("fill_full", 32'(full), 32'(1));

    // Overflow on full: sticky, count unchanged
    push(8'hAA);
    check("ovf_set", 32'(overflow), 32'(1));
    check("ovf_count", 32'(count), 32'(16));
    tick();
    check("ovf_sticky", 32'(overflow), 32'(1));

    // Drain in order; 0xAA must never appear
    for (int i = 1; i <= D; i++) begin
      pop("drain");
      check_status("drain");
    end
    check("drain_last", 32'(last_pop), 32'(8'h10));
    check("drain_empty", 32'(empty), 32'(1));
`ifndef IIITB_PFIFO_FWFT_EN
    tick();
    check("idle_ovalid", 32'(oValid), 32'(0));
    check("idle_ohold", 32'(oData), 32'(8'h10));
`endif

    // Underflow on empty, read pointer must not move
    pop("unf");
    check_status("unf");
    check("unf_set", 32'(underflow), 32'(1));
    tick();
    check("unf_sticky", 32'(underflow), 32'(1));
    push(8'h5A);
    pop("unf_after");
    check("unf_rp_kept", 32'(last_pop), 32'(8'h5A));
    flush();
    check_status("clr_unf");
    check("clr_unf_flag", 32'(underflow), 32'(0));
    check("clr_ovf_flag", 32'(overflow), 32'(0));

    // Wrap: 40 alternating push/pop, pointers cross the wrap bit several times
    for (int i = 0; i < 40; i++) begin
      push(W'(8'h40 + i));
      check_status("wrap_push");
      pop("wrap_pop");
      check_status("wrap_pop");
    end

    // Simultaneous push+pop at count 5
    for (int i = 1; i <= 5; i++) push(W'(8'h50 + i));
    push_pop(8'h56, "sim5");
    check("sim5_count", 32'(count), 32'(5));
    check("sim5_oldest", 32'(last_pop), 32'(8'h51));
    check_status("sim5");

    // Simultaneous push+pop on full: push rejected
    for (int i = 0; i < 11; i++) push(W'(8'hC0 + i));
    check("simfull_pre_full", 32'(full), 32'(1));
    push_pop(8'hBB, "simfull");
    check("simfull_count", 32'(count), 32'(15));
    check("simfull_ovf", 32'(overflow), 32'(1));
    check_status("simfull");
    while (exp_q.size() > 0) pop("simfull_drain");
    check_status("simfull_drained");

    // clear beats write and read in the same cycle
    for (int i = 0; i < 3; i++) push(W'(8'h90 + i));
    clear = 1'b1;
    write = 1'b1;
    read  = 1'b1;
    iData = 8'h99;
    tick();
    clear = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_status("clr_prio");
    check("clr_prio_ovalid", 32'(oValid), 32'(0));
    push(8'h33);
    pop("clr_prio_next");

    // Asynchronous reset mid-burst at count 7
    for (int i = 0; i < 7; i++) push(W'(8'h70 + i));
    check("arst_pre_count", 32'(count), 32'(7));
    write = 1'b1;
    iData = 8'hEE;
    @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    write = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_status("arst");
    check("arst_ovalid", 32'(oValid), 32'(0));
`ifndef IIITB_PFIFO_FWFT_EN
    check("arst_odata", 32'(oData), 32'(0));
`endif
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    push(8'h11);
    pop("post_arst");
    check_status("post_arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
